// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO transmit controller.
package piso_pkg;

    // Controller states with fixed encodings.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Gap counter width covers GAP_CYCLES up to 15.
    localparam int GAP_CNT_W = 4;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Loadable shift register; the outgoing end drives serial_out straight from a flop.
module piso_shift_core #(
    parameter int   INPUT_WIDTH = 8,
    parameter logic VALUE_PULL  = 1'b1,
    parameter bit   MSB_FIRST   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   shift,
    input  logic [INPUT_WIDTH-1:0] data,
    output logic                   serial_out
);

    logic [INPUT_WIDTH-1:0] sreg_q;
    logic [INPUT_WIDTH-1:0] sreg_d;

    // Next register contents: load a word, or move one place toward the output end.
    always_comb begin
        // NOTE: assigning a default first means no path leaves sreg_d unassigned,
        // so no latch is inferred.
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = data;
        end else if (shift) begin
            if (MSB_FIRST) begin
                sreg_d = {sreg_q[INPUT_WIDTH-2:0], VALUE_PULL};
            end else begin
                sreg_d = {VALUE_PULL, sreg_q[INPUT_WIDTH-1:1]};
            end
        end
    end

    // Register update; filling with the pull value keeps the line idle between frames.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        // The data register is reset too, because its end bit is the line itself.
        if (rst) begin
            sreg_q <= {INPUT_WIDTH{VALUE_PULL}};
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign serial_out = MSB_FIRST ? sreg_q[INPUT_WIDTH-1] : sreg_q[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Parallel-in serial-out transmitter: IDLE -> SHIFT (one bit per cycle) -> GAP -> IDLE.
module piso_tx_ctrl
    import piso_pkg::*;
#(
    parameter int   INPUT_WIDTH = 8,
    parameter logic VALUE_PULL  = 1'b1,
    parameter bit   MSB_FIRST   = 1'b1,
    parameter int   GAP_CYCLES  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_WIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   serial_out,
    output logic                   frame,
    output logic                   done,
    output logic                   busy
);

    localparam int                   CNT_W    = clog2_min1(INPUT_WIDTH);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(INPUT_WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic                   frame_q, frame_d;
    logic                   done_q, done_d;
    logic                   accept;
    logic                   load;
    logic                   shift;

    // Ready only in IDLE and never while reset is held, so a word offered during reset is dropped.
    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE);
    assign frame    = frame_q;
    assign done     = done_q;

    // Next-state, counters and the registered frame/done values.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        frame_d   = 1'b0;
        done_d    = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    bit_cnt_d = '0;
                    frame_d   = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    frame_d   = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == LAST_GAP) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and control registers; reset aborts any frame and drops a pending done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            frame_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            frame_q   <= frame_d;
            done_q    <= done_d;
        end
    end

    piso_shift_core #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .VALUE_PULL  (VALUE_PULL),
        .MSB_FIRST   (MSB_FIRST)
    ) u_shift_core (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .shift      (shift),
        .data       (in_data),
        .serial_out (serial_out)
    );

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: three configurations driven in parallel, each compared
// every cycle against a timeline model of when bits, done and idle occur.
module tb_piso_tx_ctrl;

    typedef struct {
        int          w;
        int          g;
        bit          pull;
        bit          msb;
        logic [31:0] word;
        int          start;
        bit          active;
        int          done_at;
        bit          done_v;
        int          free_at;
    } model_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;

    logic a_ready, a_ser, a_frame, a_done, a_busy;
    logic b_ready, b_ser, b_frame, b_done, b_busy;
    logic c_ready, c_ser, c_frame, c_done, c_busy;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    bit     armed = 1'b0;
    model_t ma, mb, mc;

    logic a_ser_log[$], a_frame_log[$], a_done_log[$], a_busy_log[$], a_ready_log[$];
    logic b_ser_log[$], b_frame_log[$];

    always #5 clk = ~clk;

    piso_tx_ctrl #(.INPUT_WIDTH(8), .VALUE_PULL(1'b1), .MSB_FIRST(1'b1), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(in_valid), .in_ready(a_ready),
        .serial_out(a_ser), .frame(a_frame), .done(a_done), .busy(a_busy));

    piso_tx_ctrl #(.INPUT_WIDTH(8), .VALUE_PULL(1'b1), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(in_valid), .in_ready(b_ready),
        .serial_out(b_ser), .frame(b_frame), .done(b_done), .busy(b_busy));

    piso_tx_ctrl #(.INPUT_WIDTH(5), .VALUE_PULL(1'b0), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) dut_c (
        .clk(clk), .rst(rst), .in_data(in_data[4:0]), .in_valid(in_valid), .in_ready(c_ready),
        .serial_out(c_ser), .frame(c_frame), .done(c_done), .busy(c_busy));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic model_t model_init(input int w, input int g, input bit pull, input bit msb);
        model_t m;
        m.w = w; m.g = g; m.pull = pull; m.msb = msb;
        m.word = '0; m.start = 0; m.active = 1'b0;
        m.done_at = 0; m.done_v = 1'b0; m.free_at = 0;
        return m;
    endfunction

    function automatic logic exp_frame(input model_t m);
        return m.active && (cyc >= m.start) && (cyc < m.start + m.w);
    endfunction

    function automatic logic exp_ser(input model_t m);
        int i;
        if (!exp_frame(m)) return m.pull;
        i = cyc - m.start;
        return m.msb ? m.word[m.w - 1 - i] : m.word[i];
    endfunction

    // Timeline update at the edge closing cycle cyc.
    function automatic model_t model_step(input model_t m);
        model_t r;
        r = m;
        if (rst) begin
            r.active  = 1'b0;
            r.done_v  = 1'b0;
            r.free_at = cyc + 1;
        end else if (in_valid && cyc >= m.free_at) begin
            r.word    = in_data;
            r.start   = cyc + 1;
            r.active  = 1'b1;
            r.done_at = cyc + 1 + m.w;
            r.done_v  = 1'b1;
            r.free_at = cyc + 1 + m.w + m.g;
        end
        return r;
    endfunction

    task automatic check_dut(input string n, input model_t m, input logic ser, input logic frm,
                             input logic dn, input logic rdy, input logic bsy);
        check({n, ".serial_out"}, ser, exp_ser(m));
        check({n, ".frame"}, frm, exp_frame(m));
        check({n, ".done"}, dn, m.done_v && (cyc == m.done_at));
        check({n, ".in_ready"}, rdy, !rst && (cyc >= m.free_at));
        check({n, ".busy"}, bsy, cyc < m.free_at);
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] d);
        @(negedge clk);
        rst = r;
        in_valid = v;
        in_data = d;
        #1;
        if (armed) begin
            check_dut("A", ma, a_ser, a_frame, a_done, a_ready, a_busy);
            check_dut("B", mb, b_ser, b_frame, b_done, b_ready, b_busy);
            check_dut("C", mc, c_ser, c_frame, c_done, c_ready, c_busy);
        end
        a_ser_log.push_back(a_ser);     a_frame_log.push_back(a_frame);
        a_done_log.push_back(a_done);   a_busy_log.push_back(a_busy);
        a_ready_log.push_back(a_ready);
        b_ser_log.push_back(b_ser);     b_frame_log.push_back(b_frame);
        ma = model_step(ma);
        mb = model_step(mb);
        mc = model_step(mc);
        cyc++;
        armed = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         cnt;
        int         r1, r2;
        logic [7:0] got8;

        ma = model_init(8, 1, 1'b1, 1'b1);
        mb = model_init(8, 0, 1'b1, 1'b0);
        mc = model_init(5, 3, 1'b0, 1'b1);

        // Reset, with a word offered while reset is held.
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'hFF);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        // Single 8'hD8 frame.
        k = cyc;
        step(1'b0, 1'b1, 32'hD8);
        repeat (12) step(1'b0, 1'b0, 32'h0);
        got8 = '0;
        for (int i = 1; i <= 8; i++) got8 = {got8[6:0], a_ser_log[k + i]};
        check("A.d8_msb_first_bits", got8, 8'hD8);
        cnt = 0;
        for (int i = k; i <= k + 10; i++) cnt += int'(a_frame_log[i]);
        check("A.d8_frame_len", cnt, 8);
        check("A.d8_done_k9", a_done_log[k + 9], 1'b1);
        got8 = '0;
        for (int i = 1; i <= 8; i++) got8 = {got8[6:0], b_ser_log[k + i]};
        check("B.d8_lsb_first_bits", got8, 8'h1B);
        check("B.line_before", b_ser_log[k], 1'b1);
        check("B.line_after", b_ser_log[k + 9], 1'b1);

        // Continuous valid: A5 then 3C.
        k = cyc;
        repeat (10) step(1'b0, 1'b1, 32'hA5);
        repeat (20) step(1'b0, 1'b1, 32'h3C);
        r1 = -1; r2 = -1;
        for (int i = k + 1; i < k + 30; i++) begin
            if (a_frame_log[i] && !a_frame_log[i - 1]) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
        end
        check("A.frame_period", r2 - r1, 10);
        r1 = -1; r2 = -1;
        for (int i = k + 1; i < k + 30; i++) begin
            if (b_frame_log[i] && !b_frame_log[i - 1]) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
        end
        check("B.frame_period", r2 - r1, 9);

        // Word pulsed mid-frame is ignored.
        repeat (12) step(1'b0, 1'b0, 32'h0);
        k = cyc;
        step(1'b0, 1'b1, 32'h00);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFF);
        repeat (14) step(1'b0, 1'b0, 32'h0);
        got8 = '1;
        for (int i = 1; i <= 8; i++) got8 = {got8[6:0], a_ser_log[k + i]};
        check("A.zero_frame_bits", got8, 8'h00);
        cnt = 0;
        for (int i = k; i < k + 18; i++) cnt += int'(a_frame_log[i]);
        check("A.no_second_frame", cnt, 8);

        // Reset during bit 3, then a fresh frame.
        k = cyc;
        step(1'b0, 1'b1, 32'hD8);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hD8);
        repeat (12) step(1'b0, 1'b0, 32'h0);
        check("A.abort_line", a_ser_log[k + 5], 1'b1);
        check("A.abort_frame", a_frame_log[k + 5], 1'b0);
        check("A.abort_done", a_done_log[k + 5], 1'b0);
        check("A.abort_busy", a_busy_log[k + 5], 1'b0);
        check("A.abort_ready", a_ready_log[k + 5], 1'b1);
        got8 = '0;
        for (int i = 6; i <= 13; i++) got8 = {got8[6:0], a_ser_log[k + i]};
        check("A.after_abort_bits", got8, 8'hD8);

        // Random traffic with occasional resets.
        repeat (3000) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), $urandom);
        end
        repeat (12) step(1'b0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
